keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 136 +++++++++++++
 tb/tb_keypad_scanner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces a single
// pressed key on slow scan ticks, and reports it once with a one-clk valid pulse.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] LP_N = 4'(DEBOUNCE_SCANS);

  logic       r_slow_s1;
  logic       r_slow_s2;
  logic       r_low_seen;
  logic [1:0] r_vld;
  logic [3:0] r_col_s1;
  logic [3:0] r_col_s2;

  state_t     r_state;
  logic [1:0] r_row_idx;
  logic [1:0] r_col_idx;
  logic [3:0] r_count;

  logic       w_tick;
  logic       w_single;
  logic [1:0] w_low_idx;
  logic [3:0] w_latched;

  // r_low_seen only arms once r_slow_s2 carries real input, so a slow_clk that
  // is already high when reset releases cannot masquerade as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slow_s1  <= 1'b0;
      r_slow_s2  <= 1'b0;
      r_vld      <= '0;
      r_low_seen <= 1'b0;
      r_col_s1   <= '1;
      r_col_s2   <= '1;
    end else begin
      r_slow_s1  <= slow_clk;
      r_slow_s2  <= r_slow_s1;
      r_vld      <= {r_vld[0], 1'b1};
      r_low_seen <= r_vld[1] & ~r_slow_s2;
      r_col_s1   <= col_n;
      r_col_s2   <= r_col_s1;
    end
  end

  assign w_tick    = r_slow_s2 & r_low_seen;
  assign w_latched = ~(4'b0001 << r_col_idx);
  assign row_n     = ~(4'b0001 << r_row_idx);

  always_comb begin
    w_single  = 1'b1;
    w_low_idx = 2'd0;
    case (r_col_s2)
      4'b1110: w_low_idx = 2'd0;
      4'b1101: w_low_idx = 2'd1;
      4'b1011: w_low_idx = 2'd2;
      4'b0111: w_low_idx = 2'd3;
      default: w_single  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCAN;
      r_row_idx <= 2'd0;
      r_col_idx <= 2'd0;
      r_count   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_single) begin
              r_col_idx <= w_low_idx;
              r_count   <= 4'd1;
              r_state   <= DEBOUNCE;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (r_col_s2 == w_latched) begin
              r_count <= r_count + 4'd1;
              if (r_count + 4'd1 == LP_N) begin
                r_state   <= HELD;
                key_code  <= {r_row_idx, r_col_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else begin
              r_count   <= '0;
              r_row_idx <= r_row_idx + 2'd1;
              r_state   <= SCAN;
            end
          end
          HELD: begin
            if (r_col_s2 == 4'b1111) begin
              r_count <= 4'd1;
              r_state <= RELEASE;
            end
          end
          RELEASE: begin
            if (r_col_s2 == 4'b1111) begin
              if (r_count + 4'd1 == LP_N) begin
                r_count   <= '0;
                key_held  <= 1'b0;
                r_row_idx <= r_row_idx + 2'd1;
                r_state   <= SCAN;
              end else begin
                r_count <= r_count + 4'd1;
              end
            end else begin
              r_state <= HELD;
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model plus a scoreboard of
// expected key codes consumed on every key_valid pulse.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;
  logic [3:0]  sb[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  logic        prev_kv = 1'b0;

  keypad_scanner #(.DEBOUNCE_SCANS(4)) dut (
    .clk(clk),
    .rst(rst),
    .slow_clk(slow_clk),
    .col_n(col_n),
    .row_n(row_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;
  always #100 slow_clk = ~slow_clk;

  // A column reads low only while the row of a pressed key is being driven.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge slow_clk);
  endtask

  function automatic logic [3:0] row_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (idx % 4));
  endfunction

  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1) begin
      n_valid++;
      check("valid_one_clk", 32'(prev_kv), 32'd0);
      if (sb.size() == 0) check("unexpected_valid", 32'(key_valid), 32'd0);
      else check("key_code_sb", 32'(key_code), 32'(sb.pop_front()));
    end
    prev_kv = key_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #50;
    check("rst_row_n", 32'(row_n), 32'hE);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    #100 rst = 1'b0;
    // released while slow_clk is high: no tick may follow until its next rise
    steps(1);
    check("no_tick_at_release", 32'(row_n), 32'hE);

    for (int i = 1; i <= 5; i++) begin
      steps(1);
      check("idle_row", 32'(row_n), 32'(row_of(i)));
    end

    // row 2 col 1 stable press
    keys[9] = 1'b1;
    sb.push_back(4'h9);
    steps(8);
    check("press9_held", 32'(key_held), 32'd1);
    check("press9_code", 32'(key_code), 32'h9);
    check("press9_count", 32'(n_valid), 32'd1);
    keys = '0;
    steps(3);
    check("release9_held_3", 32'(key_held), 32'd1);
    steps(1);
    check("release9_held_4", 32'(key_held), 32'd0);
    check("release9_row", 32'(row_n), 32'(row_of(3)));

    // bounce on row 1 col 3
    steps(2);
    check("bounce_row", 32'(row_n), 32'(row_of(1)));
    keys[7] = 1'b1;
    steps(2);
    keys = '0;
    steps(1);
    check("bounce_no_held", 32'(key_held), 32'd0);
    check("bounce_code_kept", 32'(key_code), 32'h9);
    keys[7] = 1'b1;
    sb.push_back(4'h7);
    steps(10);
    check("bounce_held", 32'(key_held), 32'd1);
    check("bounce_code", 32'(key_code), 32'h7);
    check("bounce_count", 32'(n_valid), 32'd2);
    keys = '0;
    steps(6);
    check("bounce_rel_held", 32'(key_held), 32'd0);
    check("bounce_rel_row", 32'(row_n), 32'(row_of(0)));

    // two keys in row 0 -> ghost pattern ignored, scan continues
    keys[0] = 1'b1;
    keys[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      steps(1);
      check("ghost_row", 32'(row_n), 32'(row_of(k)));
    end
    check("ghost_count", 32'(n_valid), 32'd2);
    keys = '0;

    // row 3 col 0 with a one-tick release glitch while held
    keys[12] = 1'b1;
    sb.push_back(4'hC);
    steps(8);
    check("glitch_held", 32'(key_held), 32'd1);
    check("glitch_code", 32'(key_code), 32'hC);
    keys = '0;
    steps(1);
    check("glitch_gap_held", 32'(key_held), 32'd1);
    keys[12] = 1'b1;
    steps(3);
    check("glitch_still_held", 32'(key_held), 32'd1);
    check("glitch_count", 32'(n_valid), 32'd3);
    keys = '0;
    steps(4);
    check("glitch_rel_held", 32'(key_held), 32'd0);
    check("glitch_rel_row", 32'(row_n), 32'(row_of(0)));

    // reset mid-debounce of row 1 col 2
    keys[6] = 1'b1;
    steps(4);
    check("dbnc_row_frozen", 32'(row_n), 32'(row_of(1)));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_row", 32'(row_n), 32'hE);
    check("async_rst_code", 32'(key_code), 32'h0);
    check("async_rst_valid", 32'(key_valid), 32'd0);
    check("async_rst_held", 32'(key_held), 32'd0);
    repeat (5) @(negedge clk);
    keys = '0;
    rst = 1'b0;
    steps(6);
    check("post_rst_count", 32'(n_valid), 32'd3);
    check("post_rst_code", 32'(key_code), 32'h0);
    check("post_rst_held", 32'(key_held), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
